// File: rtl/ep_arbiter_pkg.sv
// Shared constants for the TRN transmit-path arbiter: FSM state encodings,
// default sizing and an index-width helper.
package ep_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_GRANT      = 2'd1,
        ST_WAIT_DRIVE = 2'd2,
        ST_BUSY       = 2'd3
    } arb_state_e;

    localparam int DEFAULT_NUM_REQ        = 4;
    localparam int DEFAULT_TIMEOUT_CYCLES = 16;

    // Width of a requester index; never zero so a single requester still
    // gets a legal one-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ep_arbiter_if.sv
// Requester-side signals of the TX arbiter, grouped so the arbiter (slave)
// and the requesters (master) share one bundle.
interface ep_arbiter_if
    import ep_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ
);

    logic [NUM_REQ-1:0] req_ep;
    logic [NUM_REQ-1:0] driving_interface;
    logic [NUM_REQ-1:0] my_turn;
    logic               bus_busy;
    logic               arb_timeout;

    modport master (
        output req_ep,
        output driving_interface,
        input  my_turn,
        input  bus_busy,
        input  arb_timeout
    );

    modport slave (
        input  req_ep,
        input  driving_interface,
        output my_turn,
        output bus_busy,
        output arb_timeout
    );

endinterface

// File: rtl/ep_arbiter_rr_select.sv
// rr_select: combinational rotating priority encoder. Returns the first set
// request bit at or after ptr_i, wrapping from NUM_REQ-1 back to 0.
module ep_arbiter_rr_select
    import ep_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               valid_o,
    output logic [IDX_W-1:0]   index_o
);

    localparam logic [IDX_W:0] NUM_W = (IDX_W + 1)'(NUM_REQ);

    logic [IDX_W-1:0]   cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] hit;

    // Slot gi of the rotated view holds requester (ptr + gi) mod NUM_REQ.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            logic [IDX_W:0] sum;
            assign sum          = {1'b0, ptr_i} + (IDX_W + 1)'(gi);
            assign cand_idx[gi] = (sum >= NUM_W) ? IDX_W'(sum - NUM_W) : sum[IDX_W-1:0];
            assign hit[gi]      = req_i[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        valid_o = 1'b0;
        index_o = ptr_i;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (hit[i]) begin
                valid_o = 1'b1;
                index_o = cand_idx[i];
            end
        end
    end

endmodule

// File: rtl/ep_arbiter.sv
// Round-robin owner arbiter for the shared TRN transmit path.
// Optional grant-acceptance watchdog enabled by macro EP_ARBITER_TIMEOUT_EN.
module ep_arbiter
    import ep_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = DEFAULT_NUM_REQ,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic         trn_clk,
    input  logic         reset,
    ep_arbiter_if.slave  bus
);

    localparam int             IDX_W = idx_width(NUM_REQ);
    localparam logic [IDX_W:0] NUM_W = (IDX_W + 1)'(NUM_REQ);

    generate
        if (NUM_REQ < 1) begin : g_bad_num_req
            $error("ep_arbiter: NUM_REQ must be at least 1");
        end
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $error("ep_arbiter: TIMEOUT_CYCLES must be at least 1");
        end
    endgenerate

    arb_state_e         state_q,    state_d;
    logic [IDX_W-1:0]   owner_q,    owner_d;
    logic [IDX_W-1:0]   rr_ptr_q,   rr_ptr_d;
    logic [NUM_REQ-1:0] my_turn_q,  my_turn_d;
    logic               bus_busy_q, bus_busy_d;

    logic               sel_valid;
    logic [IDX_W-1:0]   sel_index;
    logic               owner_drive;
    logic [IDX_W:0]     owner_inc;
    logic [IDX_W-1:0]   next_ptr;

    ep_arbiter_rr_select #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_select (
        .req_i   (bus.req_ep),
        .ptr_i   (rr_ptr_q),
        .valid_o (sel_valid),
        .index_o (sel_index)
    );

    // Only the current owner's drive flag matters; all other bits are ignored.
    assign owner_drive = bus.driving_interface[owner_q];
    assign owner_inc   = {1'b0, owner_q} + (IDX_W + 1)'(1);
    assign next_ptr    = (owner_inc == NUM_W) ? '0 : owner_inc[IDX_W-1:0];

`ifdef EP_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
    logic             arb_timeout_q, arb_timeout_d;
    logic             wd_expired;

    // Counter is zero on entry to WAIT_DRIVE, so expiry lands on the
    // TIMEOUT_CYCLES-th cycle spent waiting.
    assign wd_expired = (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        my_turn_d  = '0;
        bus_busy_d = bus_busy_q;
`ifdef EP_ARBITER_TIMEOUT_EN
        wd_cnt_d      = '0;
        arb_timeout_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (sel_valid) begin
                    owner_d              = sel_index;
                    my_turn_d[sel_index] = 1'b1;
                    bus_busy_d           = 1'b1;
                    state_d              = ST_GRANT;
                end
            end
            ST_GRANT: begin
                state_d = ST_WAIT_DRIVE;
            end
            ST_WAIT_DRIVE: begin
                if (owner_drive) begin
                    state_d = ST_BUSY;
                end
`ifdef EP_ARBITER_TIMEOUT_EN
                else if (wd_expired) begin
                    arb_timeout_d = 1'b1;
                    bus_busy_d    = 1'b0;
                    rr_ptr_d      = next_ptr;
                    state_d       = ST_IDLE;
                end else begin
                    wd_cnt_d = wd_cnt_q + CNT_W'(1);
                end
`endif
            end
            ST_BUSY: begin
                if (!owner_drive) begin
                    bus_busy_d = 1'b0;
                    rr_ptr_d   = next_ptr;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge trn_clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            my_turn_q  <= '0;
            bus_busy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            my_turn_q  <= my_turn_d;
            bus_busy_q <= bus_busy_d;
        end
    end

`ifdef EP_ARBITER_TIMEOUT_EN
    always_ff @(posedge trn_clk or posedge reset) begin
        if (reset) begin
            wd_cnt_q      <= '0;
            arb_timeout_q <= 1'b0;
        end else begin
            wd_cnt_q      <= wd_cnt_d;
            arb_timeout_q <= arb_timeout_d;
        end
    end

    assign bus.arb_timeout = arb_timeout_q;
`else
    assign bus.arb_timeout = 1'b0;
`endif

    assign bus.my_turn  = my_turn_q;
    assign bus.bus_busy = bus_busy_q;

endmodule

// File: tb/tb_ep_arbiter.sv
// Directed bench for ep_arbiter with a per-cycle behavioural model and
// hand-computed checkpoints; follows EP_ARBITER_TIMEOUT_EN like the design.
module tb_ep_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic trn_clk = 1'b0;
    logic reset;

    ep_arbiter_if #(.NUM_REQ(N)) bus ();

    ep_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .trn_clk (trn_clk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 trn_clk = ~trn_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: an owner is "held" from grant until release; stage 0 is the
    // grant cycle, 1 is awaiting acceptance, 2 is actively driving.
    bit         m_held  = 0;
    int         m_owner = 0;
    int         m_ptr   = 0;
    int         m_stage = 0;
    int         m_wait  = 0;
    logic [N-1:0] exp_turn = '0;
    logic         exp_busy = 1'b0;
    logic         exp_to   = 1'b0;

    always @(posedge trn_clk or posedge reset) begin
        if (reset) begin
            m_held = 0; m_owner = 0; m_ptr = 0; m_stage = 0; m_wait = 0;
            exp_turn = '0; exp_busy = 1'b0; exp_to = 1'b0;
        end else begin
            exp_turn = '0;
            exp_to   = 1'b0;
            if (!m_held) begin
                if (bus.req_ep != '0) begin
                    m_owner = -1;
                    for (int k = 0; k < N; k++)
                        if (m_owner < 0 && bus.req_ep[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
                    m_held = 1; m_stage = 0; m_wait = 0;
                    exp_turn[m_owner] = 1'b1;
                    exp_busy = 1'b1;
                end
            end else if (m_stage == 0) begin
                m_stage = 1;
            end else if (m_stage == 1) begin
                if (bus.driving_interface[m_owner]) begin
                    m_stage = 2;
                end else begin
                    m_wait++;
`ifdef EP_ARBITER_TIMEOUT_EN
                    if (m_wait == TO) begin
                        exp_to = 1'b1; m_held = 0; exp_busy = 1'b0; m_ptr = (m_owner + 1) % N;
                    end
`endif
                end
            end else if (!bus.driving_interface[m_owner]) begin
                m_held = 0; exp_busy = 1'b0; m_ptr = (m_owner + 1) % N;
            end
        end
    end

    always @(negedge trn_clk) begin
        chk("my_turn",     bus.my_turn,     exp_turn);
        chk("bus_busy",    bus.bus_busy,    exp_busy);
        chk("arb_timeout", bus.arb_timeout, exp_to);
        chk("onehot",      ($countones(bus.my_turn) <= 1) ? 1 : 0, 1);
    end

    task automatic wait_grant(output int idx);
        idx = -1;
        for (int k = 0; k < 64; k++) begin
            @(negedge trn_clk);
            if (bus.my_turn != '0) begin
                for (int b = 0; b < N; b++) if (bus.my_turn[b]) idx = b;
                break;
            end
        end
        if (idx < 0) begin
            n_tests++; n_fail++;
            $display("FAIL grant_wait: no grant within 64 cycles, expected one (t=%0t)", $time);
        end else begin
            $display("[TB] grant -> requester %0d (t=%0t)", idx, $time);
        end
    endtask

    task automatic serve(input int dlen, output int idx);
        wait_grant(idx);
        if (idx >= 0) begin
            @(negedge trn_clk);
            bus.driving_interface[idx] = 1'b1;
            repeat (dlen) @(negedge trn_clk);
            bus.driving_interface[idx] = 1'b0;
        end
    endtask

    task automatic do_reset();
        #1 reset = 1'b1;
        bus.req_ep = '0;
        bus.driving_interface = '0;
        repeat (2) @(negedge trn_clk);
        #1 reset = 1'b0;
    endtask

    int exp_order [5] = '{0, 1, 2, 3, 0};
    int idx;
    int t_lat;

    initial begin
        reset = 1'b1;
        bus.req_ep = '0;
        bus.driving_interface = '0;
        repeat (3) @(negedge trn_clk);
        chk("reset_turn", bus.my_turn, 0);
        chk("reset_busy", bus.bus_busy, 0);
        #1 reset = 1'b0;

        // Single requester timeline: grant at cycle 1, bus_busy falls at cycle 12.
        for (int c = 0; c < 14; c++) begin
            bus.req_ep = (c == 0) ? 4'b0001 : 4'b0000;
            bus.driving_interface[0] = (c >= 3 && c <= 10);
            @(negedge trn_clk);
            chk("s1_turn",       bus.my_turn,  (c == 0) ? 1 : 0);
            chk("s1_busy",       bus.bus_busy, (c <= 10) ? 1 : 0);
            chk("s1_model_turn", exp_turn,     (c == 0) ? 1 : 0);
        end
        $display("[TB] single requester timeline done");

        // Pointer moved to 1, so requesters 0 and 1 together grant 1.
        bus.req_ep = 4'b0011;
        serve(2, idx);
        chk("s1_ptr_next", idx, 1);
        bus.req_ep = '0;
        repeat (3) @(negedge trn_clk);

        do_reset();
        bus.req_ep = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            serve(4, idx);
            chk("contention_order", idx, exp_order[i]);
        end
        bus.req_ep = '0;
        repeat (3) @(negedge trn_clk);

        // Requester 2 accepts then drops after one cycle; 3 is pending.
        bus.req_ep = 4'b1100;
        serve(1, idx);
        chk("short_owner", idx, 2);
        serve(4, idx);
        chk("short_next", idx, 3);
        bus.req_ep = '0;
        repeat (3) @(negedge trn_clk);

        bus.req_ep = 4'b0010;
        wait_grant(idx);
        chk("wd_grant", idx, 1);
`ifdef EP_ARBITER_TIMEOUT_EN
        bus.req_ep = 4'b0110;
        t_lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge trn_clk);
            if (bus.arb_timeout) begin
                t_lat = k;
                break;
            end
        end
        chk("timeout_latency", t_lat, TO + 1);
        serve(2, idx);
        chk("timeout_next", idx, 2);
        bus.req_ep = '0;
`else
        bus.req_ep = '0;
        repeat (40) @(negedge trn_clk);
        chk("hang_busy",    bus.bus_busy,    1);
        chk("hang_timeout", bus.arb_timeout, 0);
`endif
        repeat (2) @(negedge trn_clk);
        do_reset();

        // Reset while requester 3 owns the bus; restart must begin at 0.
        bus.req_ep = 4'b1000;
        wait_grant(idx);
        chk("rst_owner", idx, 3);
        bus.req_ep = '0;
        @(negedge trn_clk);
        bus.driving_interface[3] = 1'b1;
        repeat (3) @(negedge trn_clk);
        chk("rst_busy_before", bus.bus_busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_turn", bus.my_turn,     0);
        chk("rst_async_busy", bus.bus_busy,    0);
        chk("rst_async_to",   bus.arb_timeout, 0);
        repeat (2) @(negedge trn_clk);
        #1 reset = 1'b0;
        bus.driving_interface = '0;
        bus.req_ep = 4'b1001;
        serve(2, idx);
        chk("rst_restart", idx, 0);
        bus.req_ep = '0;
        repeat (3) @(negedge trn_clk);

        // Foreign driver toggling plus a request withdrawn before IDLE.
        bus.req_ep = 4'b0001;
        wait_grant(idx);
        chk("foreign_owner", idx, 0);
        bus.req_ep = 4'b0100;
        @(negedge trn_clk);
        for (int k = 0; k < 6; k++) begin
            bus.driving_interface[1] = k[0];
            if (k == 2) bus.req_ep = '0;
            @(negedge trn_clk);
        end
        chk("foreign_wait_busy", bus.bus_busy, 1);
        bus.driving_interface[0] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus.driving_interface[1] = ~k[0];
            @(negedge trn_clk);
        end
        chk("foreign_busy_busy", bus.bus_busy, 1);
        bus.driving_interface = '0;
        repeat (2) @(negedge trn_clk);
        chk("foreign_release", bus.bus_busy, 0);
        repeat (5) @(negedge trn_clk);
        chk("withdrawn_ignored", bus.my_turn, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
